// File: rtl/uart_receiver.sv
// UART receive stage: 2-flop input synchronizer, start-edge detection and
// mid-bit sampling on a SAMPLE_TICKS-x oversampling tick, LSB-first
// deserialization, and single-cycle done / framing-error strobes.
module uart_receiver #(
  parameter int WORD_BITS    = 8,
  parameter int SAMPLE_TICKS = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 rx_i,
  input  logic                 baud_i,
  output logic [WORD_BITS-1:0] data_o,
  output logic                 rx_done_o,
  output logic                 frame_err_o,
  output logic                 rx_busy_o
);

  localparam int TW = $clog2(SAMPLE_TICKS);
  localparam int BW = $clog2(WORD_BITS);

  localparam logic [TW-1:0] TICK_HALF = TW'(SAMPLE_TICKS / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [WORD_BITS-1:0] shreg;

  assign rx_s = sync_q[1];

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) sync_q <= 2'b11;
    else            sync_q <= {sync_q[0], rx_i};
  end

  // Receive FSM: start detection, mid-bit sampling, stop-bit check
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      data_o      <= '0;
      rx_done_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      rx_done_o   <= 1'b0;
      frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          // Start edge is taken immediately; the baud tick is not needed here
          tick_cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (baud_i) begin
            if (tick_cnt == TICK_HALF) begin
              // Line must still be low at mid start bit, else it was a glitch
              if (!rx_s) begin
                tick_cnt <= '0;
                bit_cnt  <= '0;
                state    <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (baud_i) begin
            if (tick_cnt == TICK_LAST) begin
              shreg    <= {rx_s, shreg[WORD_BITS-1:1]};
              tick_cnt <= '0;
              if (bit_cnt == BIT_LAST) state <= STOP;
              else                     bit_cnt <= bit_cnt + 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (baud_i) begin
            if (tick_cnt == TICK_LAST) begin
              // Return at mid stop bit so a back-to-back start edge is caught
              tick_cnt <= '0;
              state    <= IDLE;
              if (rx_s) begin
                data_o    <= shreg;
                rx_done_o <= 1'b1;
              end else begin
                frame_err_o <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver with a received-word scoreboard.
module tb_uart_receiver;

  localparam int WORD_BITS    = 8;
  localparam int SAMPLE_TICKS = 16;
  localparam int DIV          = 6;                  // clocks per baud tick
  localparam int NOM          = DIV * SAMPLE_TICKS; // clocks per bit
  localparam int FAST         = 93;                 // about -3%
  localparam int SLOW         = 99;                 // about +3%
  localparam int BAD_STOP     = (NOM * 3) / 4;      // low stop, past the sample point

  logic                 clk_i = 1'b0;
  logic                 reset_n_i;
  logic                 rx_i;
  logic                 baud_i;
  logic [WORD_BITS-1:0] data_o;
  logic                 rx_done_o;
  logic                 frame_err_o;
  logic                 rx_busy_o;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  logic [WORD_BITS-1:0] exp_q[$];

  uart_receiver #(.WORD_BITS(WORD_BITS), .SAMPLE_TICKS(SAMPLE_TICKS)) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .rx_i        (rx_i),
    .baud_i      (baud_i),
    .data_o      (data_o),
    .rx_done_o   (rx_done_o),
    .frame_err_o (frame_err_o),
    .rx_busy_o   (rx_busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Free-running baud tick, driven away from the active edge
  initial begin
    int cnt = 0;
    baud_i = 1'b0;
    forever begin
      @(negedge clk_i);
      cnt = (cnt == DIV - 1) ? 0 : cnt + 1;
      baud_i = (cnt == DIV - 1);
    end
  end

  // Output monitor: scoreboard pop on every done strobe
  always @(negedge clk_i) begin
    if (rx_done_o || frame_err_o)
      check("done_err_exclusive", {31'd0, rx_done_o & frame_err_o}, 32'd0);
    if (rx_done_o) begin
      done_cnt++;
      check("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("data_o", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
    end
    if (frame_err_o) ferr_cnt++;
  end

  task automatic send_bit(input logic b, input int clks);
    rx_i = b;
    repeat (clks) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] d, input int clks, input logic stop, input int stop_clks);
    send_bit(1'b0, clks);
    for (int i = 0; i < WORD_BITS; i++) send_bit(d[i], clks);
    send_bit(stop, stop_clks);
    rx_i = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || rx_busy_o) && n < 4000) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, {31'd0, n < 4000}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, f0;
    reset_n_i = 1'b0;
    rx_i      = 1'b1;
    repeat (5) @(negedge clk_i);
    check("reset_data",  {24'd0, data_o}, 32'd0);
    check("reset_done",  {31'd0, rx_done_o}, 32'd0);
    check("reset_ferr",  {31'd0, frame_err_o}, 32'd0);
    check("reset_busy",  {31'd0, rx_busy_o}, 32'd0);
    reset_n_i = 1'b1;
    repeat (NOM) @(negedge clk_i);
    check("idle_busy", {31'd0, rx_busy_o}, 32'd0);

    // Single frame
    exp_q.push_back(8'h55);
    send_frame(8'h55, NOM, 1'b1, NOM);
    drain("single_drain");
    check("single_cnt",  done_cnt, 1);
    check("single_data", {24'd0, data_o}, 32'h55);
    check("single_busy", {31'd0, rx_busy_o}, 32'd0);
    check("single_ferr", ferr_cnt, 0);

    // Back-to-back frames
    exp_q.push_back(8'hCC);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'hCC, NOM, 1'b1, NOM);
    send_frame(8'h00, NOM, 1'b1, NOM);
    send_frame(8'hFF, NOM, 1'b1, NOM);
    drain("b2b_drain");
    check("b2b_cnt",  done_cnt, 4);
    check("b2b_data", {24'd0, data_o}, 32'hFF);
    check("b2b_ferr", ferr_cnt, 0);

    // False start: low for 3 baud ticks only
    d0 = done_cnt;
    rx_i = 1'b0;
    repeat (3 * DIV) @(negedge clk_i);
    check("false_busy_high", {31'd0, rx_busy_o}, 32'd1);
    rx_i = 1'b1;
    repeat (2 * NOM) @(negedge clk_i);
    check("false_busy_low", {31'd0, rx_busy_o}, 32'd0);
    check("false_no_done", done_cnt, d0);
    check("false_data", {24'd0, data_o}, 32'hFF);
    check("false_no_ferr", ferr_cnt, 0);

    // Framing error: stop bit low
    send_frame(8'hA5, NOM, 1'b0, BAD_STOP);
    repeat (2 * NOM) @(negedge clk_i);
    check("ferr_cnt", ferr_cnt, 1);
    check("ferr_no_done", done_cnt, d0);
    check("ferr_data_kept", {24'd0, data_o}, 32'hFF);
    check("ferr_busy", {31'd0, rx_busy_o}, 32'd0);

    // Reset during data bit 3 of 0x3C
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_bit(1'b0, NOM);
    send_bit(1'b0, NOM);
    send_bit(1'b0, NOM);
    send_bit(1'b1, NOM);
    send_bit(1'b1, NOM / 2);
    reset_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_busy",  {31'd0, rx_busy_o}, 32'd0);
    check("rst_data",  {24'd0, data_o}, 32'd0);
    rx_i = 1'b1;
    reset_n_i = 1'b1;
    repeat (10 * NOM) @(negedge clk_i);
    check("rst_no_done", done_cnt, d0);
    check("rst_no_ferr", ferr_cnt, f0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, NOM, 1'b1, NOM);
    drain("rst_drain");
    check("rst_after_cnt",  done_cnt, d0 + 1);
    check("rst_after_data", {24'd0, data_o}, 32'h81);

    // Baud tolerance, slow then fast line
    exp_q.push_back(8'h96);
    send_frame(8'h96, SLOW, 1'b1, SLOW);
    drain("slow_drain");
    check("slow_data", {24'd0, data_o}, 32'h96);
    exp_q.push_back(8'h69);
    send_frame(8'h69, FAST, 1'b1, FAST);
    drain("fast_drain");
    check("fast_data", {24'd0, data_o}, 32'h69);
    check("tol_ferr", ferr_cnt, f0);
    check("total_done", done_cnt, d0 + 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
